// File: rtl/branch_resolve_unit_pkg.sv
// Shared core types for branch resolution.
// Holds br_op_t and the predictor_update bundle.
package branch_resolve_unit_pkg;

  localparam int unsigned CORE_ROB_INDEX_BITS = 3;
  localparam int unsigned CORE_RAT_ID_BITS = 1;

  typedef enum logic [3:0] {
    BEQ,
    BNE,
    BLT,
    BGE,
    BLTU,
    BGEU,
    JAL,
    JALR,
    CSR
  } br_op_t;

  typedef struct packed {
    logic                           valid_jump;
    logic                           jump_taken;
    logic [31:0]                    jump_address;
    logic [31:0]                    orig_pc;
    logic                           is_comp;
    logic                           csr_branch;
    logic [CORE_ROB_INDEX_BITS-1:0] ticket;
    logic [CORE_RAT_ID_BITS-1:0]    rat_id;
  } predictor_update;

endpackage

// File: rtl/branch_resolve_unit_compare.sv
// branch_compare: combinational condition and target.
// Ports: op, pc, rs1, rs2, imm, csr_target -> taken, target.
module branch_compare
  import branch_resolve_unit_pkg::*;
(
  input  br_op_t      op,
  input  logic [31:0] pc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] imm,
  input  logic [31:0] csr_target,
  output logic        taken,
  output logic [31:0] target
);

  logic [31:0] jalr_sum;

  assign jalr_sum = rs1 + imm;

  always_comb begin
    taken  = 1'b0;
    target = pc + imm;
    unique case (op)
      BEQ:  taken = (rs1 == rs2);
      BNE:  taken = (rs1 != rs2);
      BLT:  taken = ($signed(rs1) < $signed(rs2));
      BGE:  taken = ($signed(rs1) >= $signed(rs2));
      BLTU: taken = (rs1 < rs2);
      BGEU: taken = (rs1 >= rs2);
      JAL:  taken = 1'b1;
      JALR: begin
        taken  = 1'b1;
        target = jalr_sum & 32'hFFFF_FFFE;
      end
      CSR: begin
        taken  = 1'b1;
        target = csr_target;
      end
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolver: S1 issue latch, S2 report/writeback.
// Ports: clk, rst, issue handshake (valid_i/ready_o + operands, tags),
// flush_i, pr_update to predictor, wb_* link writeback handshake.
// Macro RVC_BRANCH_EN honours is_comp_i (pc+2 link); default pc+4.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned ROB_INDEX_BITS = CORE_ROB_INDEX_BITS,
  parameter int unsigned MAX_BRANCH_IF  = 2,
  localparam int unsigned RAT_BITS =
    (MAX_BRANCH_IF > 1) ? $clog2(MAX_BRANCH_IF) : 1
)
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [31:0]               pc_i,
  input  logic [31:0]               rs1_i,
  input  logic [31:0]               rs2_i,
  input  logic [31:0]               imm_i,
  input  br_op_t                    br_op_i,
  input  logic                      is_comp_i,
  input  logic [31:0]               csr_target_i,
  input  logic [ROB_INDEX_BITS-1:0] ticket_i,
  input  logic [RAT_BITS-1:0]       rat_id_i,
  input  logic                      flush_i,
  output predictor_update           pr_update,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [31:0]               wb_data_o,
  output logic [ROB_INDEX_BITS-1:0] wb_ticket_o
);

  logic                      comp_in;

`ifdef RVC_BRANCH_EN
  assign comp_in = is_comp_i;
`else
  logic unused_comp;
  assign unused_comp = is_comp_i;
  assign comp_in     = 1'b0;
`endif

  logic                      s1_valid;
  logic [31:0]               s1_pc;
  logic [31:0]               s1_rs1;
  logic [31:0]               s1_rs2;
  logic [31:0]               s1_imm;
  br_op_t                    s1_op;
  logic                      s1_comp;
  logic [31:0]               s1_csr;
  logic [ROB_INDEX_BITS-1:0] s1_ticket;
  logic [RAT_BITS-1:0]       s1_rat;

  logic                      s2_valid;
  logic                      s2_reported;
  logic                      s2_taken;
  logic [31:0]               s2_target;
  logic [31:0]               s2_pc;
  logic [31:0]               s2_link;
  logic                      s2_is_link;
  logic                      s2_is_csr;
  logic                      s2_comp;
  logic [ROB_INDEX_BITS-1:0] s2_ticket;
  logic [RAT_BITS-1:0]       s2_rat;

  logic                      cmp_taken;
  logic [31:0]               cmp_target;
  logic [31:0]               s1_link;
  logic                      s1_is_link;
  logic                      s2_retire;
  logic                      s1_adv;
  logic                      accept;
  logic                      s2_first;

  branch_compare u_cmp (
    .op         (s1_op),
    .pc         (s1_pc),
    .rs1        (s1_rs1),
    .rs2        (s1_rs2),
    .imm        (s1_imm),
    .csr_target (s1_csr),
    .taken      (cmp_taken),
    .target     (cmp_target)
  );

  assign s1_link    = s1_pc + (s1_comp ? 32'd2 : 32'd4);
  assign s1_is_link = (s1_op == JAL) || (s1_op == JALR);

  // Link ops wait for the writeback handshake; others leave
  // S2 right after their single report cycle.
  assign s2_retire = s2_valid && (!s2_is_link || wb_ready_i);
  assign s1_adv    = s1_valid && (!s2_valid || s2_retire);
  assign ready_o   = !flush_i && (!s1_valid || s1_adv);
  assign accept    = valid_i && ready_o;
  assign s2_first  = s2_valid && !s2_reported;

  always_comb begin
    pr_update              = '0;
    pr_update.valid_jump   = s2_first && !s2_is_csr;
    pr_update.csr_branch   = s2_first && s2_is_csr;
    pr_update.jump_taken   = s2_taken;
    pr_update.jump_address = s2_target;
    pr_update.orig_pc      = s2_pc;
    pr_update.is_comp      = s2_comp;
    pr_update.ticket       = CORE_ROB_INDEX_BITS'(s2_ticket);
    pr_update.rat_id       = CORE_RAT_ID_BITS'(s2_rat);
  end

  assign wb_valid_o  = s2_valid && s2_is_link;
  assign wb_data_o   = s2_link;
  assign wb_ticket_o = s2_ticket;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s2_reported <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv) begin
        s2_valid    <= 1'b1;
        s2_reported <= 1'b0;
      end else if (s2_retire) begin
        s2_valid    <= 1'b0;
        s2_reported <= 1'b0;
      end else if (s2_valid) begin
        s2_reported <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_pc     <= pc_i;
      s1_rs1    <= rs1_i;
      s1_rs2    <= rs2_i;
      s1_imm    <= imm_i;
      s1_op     <= br_op_i;
      s1_comp   <= comp_in;
      s1_csr    <= csr_target_i;
      s1_ticket <= ticket_i;
      s1_rat    <= rat_id_i;
    end
    if (s1_adv) begin
      s2_taken   <= cmp_taken;
      s2_target  <= cmp_target;
      s2_pc      <= s1_pc;
      s2_link    <= s1_link;
      s2_is_link <= s1_is_link;
      s2_is_csr  <= (s1_op == CSR);
      s2_comp    <= s1_comp;
      s2_ticket  <= s1_ticket;
      s2_rat     <= s1_rat;
    end
  end

endmodule
